// File: rtl/divider_pkg.sv
// Shared types and constant helpers for the parametrised iterative divider.
package divider_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Iteration counter width; it must be able to hold WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // All-ones pattern for a w-bit word, returned in a 32-bit container.
  function automatic logic [31:0] all_ones(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Most negative two's-complement value of a w-bit word.
  function automatic logic [31:0] min_val(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division iteration, purely combinational.
module divider_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift in the next dividend bit and trial-subtract on a WIDTH+1-bit path.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, dvs_mag};
    q_bit   = (shifted >= {1'b0, dvs_mag});
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_param.sv
// Parametrised iterative divider: one quotient bit per clock, fixed latency
// WIDTH+1, unsigned or two's-complement operands.
module divider_param
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic             o_overflow
);

  localparam int unsigned      CW       = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ONES     = WIDTH'(all_ones(WIDTH));
  localparam logic [WIDTH-1:0] MINV     = WIDTH'(min_val(WIDTH));
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic             neg_q, neg_r, ovf_pend;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_nx, q_full, q_fin, r_fin;
  logic             q_bit;
  logic             div_zero;

  // Operand magnitudes as seen in the accept cycle.
  always_comb begin
    div_zero = (i_divisor == '0);
    a_mag    = i_dividend;
    b_mag    = i_divisor;
    if (SIGNED && i_dividend[WIDTH-1]) a_mag = -i_dividend;
    if (SIGNED && i_divisor[WIDTH-1])  b_mag = -i_divisor;
  end

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dq[WIDTH-1]),
    .dvs_mag (dvs),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // dq starts as the dividend magnitude and fills with quotient bits from
  // the LSB as dividend bits leave at the MSB.
  always_comb begin
    q_full = {dq[WIDTH-2:0], q_bit};
    q_fin  = neg_q ? -q_full : q_full;
    r_fin  = neg_r ? -rem_nx : rem_nx;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start && !div_zero) state_nx = CALC;
      CALC:    if (cnt == '0)            state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy = (state == CALC);
  end

  // Datapath, result registers and done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt           <= '0;
      rem           <= '0;
      dq            <= '0;
      dvs           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      ovf_pend      <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (div_zero) begin
              o_quotient    <= ONES;
              o_remainder   <= i_dividend;
              o_div_by_zero <= 1'b1;
              o_overflow    <= 1'b0;
              o_done        <= 1'b1;
            end else begin
              dq       <= a_mag;
              dvs      <= b_mag;
              rem      <= '0;
              cnt      <= LAST_CNT;
              neg_q    <= SIGNED && (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
              neg_r    <= SIGNED && i_dividend[WIDTH-1];
              ovf_pend <= SIGNED && (i_dividend == MINV) && (i_divisor == ONES);
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          dq  <= q_full;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            o_quotient    <= q_fin;
            o_remainder   <= r_fin;
            o_div_by_zero <= 1'b0;
            o_overflow    <= ovf_pend;
            o_done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_param.sv
// Scoreboard bench: an unsigned and a signed 8-bit divider share one stimulus
// stream; expected results come from plain integer division.
module tb_divider_param;

  localparam int unsigned W = 8;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_dividend = '0;
  logic [7:0] i_divisor = '0;

  logic       busy_u, done_u, dz_u, ov_u;
  logic [7:0] q_u, r_u;
  logic       busy_s, done_s, dz_s, ov_s;
  logic [7:0] q_s, r_s;

  always #5 i_clk = ~i_clk;

  divider_param #(.WIDTH(W), .SIGNED(1'b0)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dividend(i_dividend), .i_divisor(i_divisor),
    .i_start(i_start), .o_busy(busy_u), .o_done(done_u), .o_quotient(q_u),
    .o_remainder(r_u), .o_div_by_zero(dz_u), .o_overflow(ov_u)
  );

  divider_param #(.WIDTH(W), .SIGNED(1'b1)) s_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dividend(i_dividend), .i_divisor(i_divisor),
    .i_start(i_start), .o_busy(busy_s), .o_done(done_s), .o_quotient(q_s),
    .o_remainder(r_s), .o_div_by_zero(dz_s), .o_overflow(ov_s)
  );

  typedef struct {
    int         due;
    logic [7:0] uq, ur;
    logic       udz;
    logic [7:0] sq, sr;
    logic       sdz, sov;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   pe = 0;
  logic rst_q = 1'b0;

  logic [7:0] hu_q = '0, hu_r = '0, hs_q = '0, hs_r = '0;
  logic       hu_dz = 1'b0, hs_dz = 1'b0, hs_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, req, pe);
    end
  endtask

  // Reference: integer division, C-style truncation toward zero for signed.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int due);
    exp_t e;
    int   sa, sbv;
    sa    = int'($signed(a));
    sbv   = int'($signed(b));
    e.due = due;
    e.udz = 1'b0;
    e.sdz = 1'b0;
    e.sov = 1'b0;
    if (b == 8'd0) begin
      e.uq = 8'hFF; e.ur = a; e.udz = 1'b1;
      e.sq = 8'hFF; e.sr = a; e.sdz = 1'b1;
    end else begin
      e.uq = a / b;
      e.ur = a % b;
      if (sa == -128 && sbv == -1) begin
        e.sq = 8'h80; e.sr = 8'h00; e.sov = 1'b1;
      end else begin
        e.sq = 8'(sa / sbv);
        e.sr = 8'(sa % sbv);
      end
    end
    return e;
  endfunction

  always @(posedge i_clk) begin
    pe    <= pe + 1;
    rst_q <= i_rst;
  end

  // Monitor: checks reset state, each done against the scoreboard, and that
  // results hold steady between loads.
  always @(negedge i_clk) begin
    if (pe > 0) begin
      if (rst_q) begin
        chk("reset_u", {busy_u, done_u, dz_u, ov_u, q_u, r_u}, 32'd0);
        chk("reset_s", {busy_s, done_s, dz_s, ov_s, q_s, r_s}, 32'd0);
        sb.delete();
        hu_q = '0; hu_r = '0; hs_q = '0; hs_r = '0;
        hu_dz = 1'b0; hs_dz = 1'b0; hs_ov = 1'b0;
      end else if (done_u || done_s) begin
        chk("done_u", done_u, 1);
        chk("done_s", done_s, 1);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done with no request outstanding (edge %0d)", pe);
        end else begin
          me = sb.pop_front();
          chk("latency", pe, me.due);
          chk("u_quot", q_u, me.uq);
          chk("u_rem", r_u, me.ur);
          chk("u_dbz", dz_u, me.udz);
          chk("u_ovf", ov_u, 0);
          chk("s_quot", q_s, me.sq);
          chk("s_rem", r_s, me.sr);
          chk("s_dbz", dz_s, me.sdz);
          chk("s_ovf", ov_s, me.sov);
          hu_q = me.uq; hu_r = me.ur; hu_dz = me.udz;
          hs_q = me.sq; hs_r = me.sr; hs_dz = me.sdz; hs_ov = me.sov;
        end
      end else begin
        chk("hold_u", {q_u, r_u, dz_u, ov_u}, {hu_q, hu_r, hu_dz, 1'b0});
        chk("hold_s", {q_s, r_s, dz_s, ov_s}, {hs_q, hs_r, hs_dz, hs_ov});
      end
    end
  end

  // Caller is at a negedge; issues a one-cycle start and scrambles operands.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    sb.push_back(model(a, b, pe + ((b == 8'd0) ? 1 : int'(W) + 1)));
    @(negedge i_clk);
    i_start    = 1'b0;
    i_dividend = 8'($urandom);
    i_divisor  = 8'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done_u) return;
      @(negedge i_clk);
    end
    total++;
    bad++;
    $display("FAIL done_timeout: got no done within 40 cycles, want done (edge %0d)", pe);
  endtask

  initial begin
    logic [7:0] a, b;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    // 200/7 with busy trace across N+1..N+8, idle at N+9
    start_op(8'd200, 8'd7);
    for (int k = 1; k <= int'(W); k++) begin
      chk("busy_u", busy_u, 1);
      chk("busy_s", busy_s, 1);
      @(negedge i_clk);
    end
    chk("busy_end_u", busy_u, 0);
    wait_done();

    // Divide by zero: done next cycle, never busy
    @(negedge i_clk);
    start_op(8'd45, 8'd0);
    chk("dbz_busy_u", busy_u, 0);
    chk("dbz_busy_s", busy_s, 0);
    wait_done();

    // Signed sign cases and MIN / -1
    @(negedge i_clk); start_op(8'hF9, 8'd2);  wait_done();
    @(negedge i_clk); start_op(8'd7, 8'hFE);  wait_done();
    @(negedge i_clk); start_op(8'h80, 8'hFF); wait_done();

    // Start while busy is ignored; start in the done cycle is accepted
    @(negedge i_clk);
    start_op(8'd100, 8'd3);
    @(negedge i_clk);
    @(negedge i_clk);
    i_dividend = 8'd50; i_divisor = 8'd5; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done();
    start_op(8'd9, 8'd4);
    wait_done();

    // Reset mid-operation aborts; the next division is normal
    @(negedge i_clk);
    start_op(8'd77, 8'd5);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (12) @(negedge i_clk);
    start_op(8'd77, 8'd5);
    wait_done();

    // Randomised operands, including zero divisor, -1 and MIN dividend
    for (int n = 0; n < 80; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(7) == 0) b = 8'd0;
      if ($urandom_range(7) == 0) b = 8'hFF;
      if ($urandom_range(7) == 0) a = 8'h80;
      if ($urandom_range(2) != 0) repeat ($urandom_range(3, 1)) @(negedge i_clk);
      start_op(a, b);
      wait_done();
    end

    repeat (3) @(negedge i_clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
